// File: rtl/dynamic_output_arb_para_if.sv
// Link bundle between the per-input route-decode stage and one dynamic-network output port.
interface dynamic_output_arb_para_if #(
  parameter int NUM_IN     = 5,
  parameter int DATA_WIDTH = 64,
  parameter int CREDITS    = 4
);
  localparam int CW = $clog2(CREDITS + 1);

  logic [NUM_IN-1:0]            route_req_in;
  logic [NUM_IN-1:0]            tail_in;
  logic [NUM_IN-1:0]            valid_in;
  logic [NUM_IN*DATA_WIDTH-1:0] data_in;
  logic                         yummy_in;
  logic [DATA_WIDTH-1:0]        data_out;
  logic                         valid_out;
  logic [NUM_IN-1:0]            thanks_out;
  logic                         popped_header_out;
  logic [CW-1:0]                credit_count_out;
  logic                         credit_err_out;
  logic                         ec_wants_to_send_but_cannot;

  modport master (
    output route_req_in, tail_in, valid_in, data_in, yummy_in,
    input  data_out, valid_out, thanks_out, popped_header_out,
           credit_count_out, credit_err_out, ec_wants_to_send_but_cannot
  );

  modport slave (
    input  route_req_in, tail_in, valid_in, data_in, yummy_in,
    output data_out, valid_out, thanks_out, popped_header_out,
           credit_count_out, credit_err_out, ec_wants_to_send_but_cannot
  );
endinterface

// File: rtl/dynamic_output_arb_para.sv
// Wormhole output port: round-robin grant across NUM_IN channels, credit flow control,
// optional header stripping.
//   state     | meaning
//   ST_IDLE   | link free, arbitrating over route requests
//   ST_LOCKED | link owned by owner_q until its tail flit is consumed
module dynamic_output_arb_para #(
  parameter int NUM_IN       = 5,
  parameter int DATA_WIDTH   = 64,
  parameter int CREDITS      = 4,
  parameter int KILL_HEADERS = 0
) (
  input logic                      clk,
  input logic                      reset,
  dynamic_output_arb_para_if.slave link
);
  localparam int IW = $clog2(NUM_IN);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [IW-1:0] LAST_CH  = IW'(NUM_IN - 1);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            first_flit_q, first_flit_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic            credit_err_q, credit_err_d;

  logic [IW-1:0]   winner;
  logic            any_req;
  logic [IW:0]     probe;
  logic            locked, strip, go, send;
  logic            own_valid, own_tail;
  logic [DATA_WIDTH-1:0] own_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      first_flit_q <= 1'b1;
      credit_q     <= CRED_MAX;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      first_flit_q <= first_flit_d;
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
    end
  end

  // Round-robin search starting at rr_ptr_q, wrapping modulo NUM_IN.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    probe   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      probe = {1'b0, rr_ptr_q} + (IW+1)'(i);
      if (probe >= (IW+1)'(NUM_IN)) probe = probe - (IW+1)'(NUM_IN);
      if (!any_req && link.route_req_in[probe[IW-1:0]]) begin
        any_req = 1'b1;
        winner  = probe[IW-1:0];
      end
    end
  end

  // Outputs are forced quiet while reset is held, even if the old state was LOCKED.
  always_comb begin
    locked    = (state_q == ST_LOCKED) && !reset;
    own_valid = link.valid_in[owner_q];
    own_tail  = link.tail_in[owner_q];
    own_data  = link.data_in[owner_q*DATA_WIDTH +: DATA_WIDTH];
    strip     = (KILL_HEADERS != 0) && first_flit_q;
    go        = locked && own_valid && (strip || (credit_q != '0));
    send      = go && !strip;

    link.data_out          = send ? own_data : '0;
    link.valid_out         = send;
    link.thanks_out        = go ? (NUM_IN'(1) << owner_q) : '0;
    link.popped_header_out = go && strip;
    link.credit_count_out  = credit_q;
    link.credit_err_out    = credit_err_q;
    link.ec_wants_to_send_but_cannot = locked && own_valid && !strip && (credit_q == '0);
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    first_flit_d = first_flit_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d      = winner;
          first_flit_d = 1'b1;
          state_d      = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (go) begin
          first_flit_d = 1'b0;
          if (own_tail) begin
            state_d      = ST_IDLE;
            first_flit_d = 1'b1;
            rr_ptr_d     = (owner_q == LAST_CH) ? '0 : owner_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A send and a returning credit in the same cycle cancel out.
  always_comb begin
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    if (send && !link.yummy_in) begin
      credit_d = credit_q - 1'b1;
    end else if (!send && link.yummy_in) begin
      if (credit_q == CRED_MAX) credit_err_d = 1'b1;
      else                      credit_d     = credit_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_dynamic_output_arb_para.sv
// Directed bench for dynamic_output_arb_para: one instance without and one with header stripping.
module tb_dynamic_output_arb_para;
  localparam int N  = 5;
  localparam int DW = 16;
  localparam int CR = 4;

  logic clk;
  logic reset;
  logic [N-1:0]    route_req, tail, valid;
  logic [N*DW-1:0] data;
  logic            yummy;

  int n_chk;
  int n_fail;

  dynamic_output_arb_para_if #(.NUM_IN(N), .DATA_WIDTH(DW), .CREDITS(CR)) bus0 ();
  dynamic_output_arb_para_if #(.NUM_IN(N), .DATA_WIDTH(DW), .CREDITS(CR)) bus1 ();

  assign bus0.route_req_in = route_req;
  assign bus0.tail_in      = tail;
  assign bus0.valid_in     = valid;
  assign bus0.data_in      = data;
  assign bus0.yummy_in     = yummy;
  assign bus1.route_req_in = route_req;
  assign bus1.tail_in      = tail;
  assign bus1.valid_in     = valid;
  assign bus1.data_in      = data;
  assign bus1.yummy_in     = yummy;

  dynamic_output_arb_para #(.NUM_IN(N), .DATA_WIDTH(DW), .CREDITS(CR), .KILL_HEADERS(0)) dut0 (
    .clk(clk), .reset(reset), .link(bus0)
  );
  dynamic_output_arb_para #(.NUM_IN(N), .DATA_WIDTH(DW), .CREDITS(CR), .KILL_HEADERS(1)) dut1 (
    .clk(clk), .reset(reset), .link(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    route_req = '0;
    tail      = '0;
    valid     = '0;
    data      = '0;
    yummy     = 1'b0;
  endtask

  task automatic set_d(input int ch, input logic [DW-1:0] v);
    data[ch*DW +: DW] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_in();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    // reset values
    reset = 1'b1;
    clear_in();
    tick();
    #1;
    chk("rst_valid",   bus0.valid_out, 0);
    chk("rst_thanks",  bus0.thanks_out, 0);
    chk("rst_credit",  bus0.credit_count_out, 4);
    chk("rst_err",     bus0.credit_err_out, 0);
    chk("rst_popped",  bus1.popped_header_out, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_ec",      bus0.ec_wants_to_send_but_cannot, 0);
    chk("rst_data",    bus0.data_out, 0);

    // channel 2, 3-flit packet
    route_req = 5'b00100;
    valid     = 5'b00100;
    set_d(2, 16'hA001);
    #1;
    chk("t2_grant_valid",  bus0.valid_out, 0);
    chk("t2_grant_thanks", bus0.thanks_out, 0);
    tick();
    #1;
    chk("t2_f1_valid",  bus0.valid_out, 1);
    chk("t2_f1_thanks", bus0.thanks_out, 5'b00100);
    chk("t2_f1_data",   bus0.data_out, 16'hA001);
    chk("t2_f1_credit", bus0.credit_count_out, 4);
    tick();
    set_d(2, 16'hA002);
    #1;
    chk("t2_f2_valid",  bus0.valid_out, 1);
    chk("t2_f2_thanks", bus0.thanks_out, 5'b00100);
    chk("t2_f2_data",   bus0.data_out, 16'hA002);
    chk("t2_f2_credit", bus0.credit_count_out, 3);
    tick();
    set_d(2, 16'hA003);
    tail = 5'b00100;
    #1;
    chk("t2_f3_valid",  bus0.valid_out, 1);
    chk("t2_f3_thanks", bus0.thanks_out, 5'b00100);
    chk("t2_f3_data",   bus0.data_out, 16'hA003);
    chk("t2_f3_credit", bus0.credit_count_out, 2);
    tick();
    clear_in();
    #1;
    chk("t2_end_credit", bus0.credit_count_out, 1);
    chk("t2_end_valid",  bus0.valid_out, 0);

    // channels 0 and 3 contend with single-flit packets
    do_reset();
    route_req = 5'b01001;
    valid     = 5'b01001;
    tail      = 5'b01001;
    set_d(0, 16'hB000);
    set_d(3, 16'hB003);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_idle_thanks", bus0.thanks_out, 0);
      tick();
      #1;
      chk("t3_grant", bus0.thanks_out, (k % 2 == 0) ? 5'b00001 : 5'b01000);
      chk("t3_data",  bus0.data_out, (k % 2 == 0) ? 16'hB000 : 16'hB003);
      tick();
    end
    clear_in();
    #1;
    chk("t3_credit", bus0.credit_count_out, 0);

    // credit exhaustion and single-yummy release
    do_reset();
    route_req = 5'b10000;
    valid     = 5'b10000;
    set_d(4, 16'hC004);
    #1;
    chk("t4_grant_valid", bus0.valid_out, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t4_send",   bus0.valid_out, 1);
      chk("t4_credit", bus0.credit_count_out, 4 - k);
      tick();
    end
    #1;
    chk("t4_stall_valid",  bus0.valid_out, 0);
    chk("t4_stall_ec",     bus0.ec_wants_to_send_but_cannot, 1);
    chk("t4_stall_thanks", bus0.thanks_out, 0);
    tick();
    #1;
    chk("t4_stall2_ec", bus0.ec_wants_to_send_but_cannot, 1);
    yummy = 1'b1;
    #1;
    chk("t4_yummy_cycle_valid", bus0.valid_out, 0);
    tick();
    yummy = 1'b0;
    #1;
    chk("t4_one_credit", bus0.credit_count_out, 1);
    chk("t4_one_send",   bus0.valid_out, 1);
    chk("t4_one_ec",     bus0.ec_wants_to_send_but_cannot, 0);
    tick();
    #1;
    chk("t4_only_one_valid", bus0.valid_out, 0);
    chk("t4_only_one_ec",    bus0.ec_wants_to_send_but_cannot, 1);
    chk("t4_only_one_cred",  bus0.credit_count_out, 0);
    yummy = 1'b1;
    tick();
    yummy = 1'b0;
    tail  = 5'b10000;
    #1;
    chk("t4_tail_valid", bus0.valid_out, 1);
    tick();
    clear_in();
    #1;
    chk("t4_end_credit", bus0.credit_count_out, 0);
    chk("t4_end_ec",     bus0.ec_wants_to_send_but_cannot, 0);

    // yummy coinciding with send, then overflow
    yummy = 1'b1;
    tick();
    tick();
    yummy = 1'b0;
    #1;
    chk("t5_credit2", bus0.credit_count_out, 2);
    route_req = 5'b00010;
    valid     = 5'b00010;
    set_d(1, 16'hD001);
    tick();
    yummy = 1'b1;
    #1;
    chk("t5_f1_valid", bus0.valid_out, 1);
    tick();
    yummy = 1'b0;
    tail  = 5'b00010;
    #1;
    chk("t5_same_cycle", bus0.credit_count_out, 2);
    chk("t5_f2_valid",   bus0.valid_out, 1);
    tick();
    clear_in();
    #1;
    chk("t5_after", bus0.credit_count_out, 1);
    yummy = 1'b1;
    repeat (3) tick();
    yummy = 1'b0;
    #1;
    chk("t5_full",    bus0.credit_count_out, 4);
    chk("t5_no_err",  bus0.credit_err_out, 0);
    yummy = 1'b1;
    tick();
    yummy = 1'b0;
    #1;
    chk("t5_sat",     bus0.credit_count_out, 4);
    chk("t5_err",     bus0.credit_err_out, 1);
    repeat (3) tick();
    #1;
    chk("t5_err_sticky", bus0.credit_err_out, 1);

    // header stripping on the KILL_HEADERS instance
    do_reset();
    #1;
    chk("t6_err_cleared", bus0.credit_err_out, 0);
    route_req = 5'b00010;
    valid     = 5'b00010;
    set_d(1, 16'hE0E0);
    #1;
    chk("t6_grant_popped", bus1.popped_header_out, 0);
    tick();
    #1;
    chk("t6_hdr_popped", bus1.popped_header_out, 1);
    chk("t6_hdr_valid",  bus1.valid_out, 0);
    chk("t6_hdr_thanks", bus1.thanks_out, 5'b00010);
    chk("t6_hdr_credit", bus1.credit_count_out, 4);
    tick();
    set_d(1, 16'hE001);
    tail = 5'b00010;
    #1;
    chk("t6_pl_valid",  bus1.valid_out, 1);
    chk("t6_pl_data",   bus1.data_out, 16'hE001);
    chk("t6_pl_thanks", bus1.thanks_out, 5'b00010);
    chk("t6_pl_popped", bus1.popped_header_out, 0);
    tick();
    clear_in();
    #1;
    chk("t6_end_credit", bus1.credit_count_out, 3);
    chk("t6_end_thanks", bus1.thanks_out, 0);
    route_req = 5'b00001;
    valid     = 5'b00001;
    tail      = 5'b00001;
    tick();
    #1;
    chk("t6_single_popped", bus1.popped_header_out, 1);
    chk("t6_single_valid",  bus1.valid_out, 0);
    chk("t6_single_thanks", bus1.thanks_out, 5'b00001);
    tick();
    #1;
    chk("t6_single_release_valid",  bus1.valid_out, 0);
    chk("t6_single_release_thanks", bus1.thanks_out, 0);
    clear_in();

    // reset in the middle of a packet
    do_reset();
    route_req = 5'b01000;
    valid     = 5'b01000;
    tail      = 5'b01000;
    tick();
    tick();
    clear_in();
    route_req = 5'b00100;
    valid     = 5'b00100;
    tick();
    tick();
    tick();
    #1;
    chk("t7_mid_credit", bus0.credit_count_out, 1);
    chk("t7_mid_valid",  bus0.valid_out, 1);
    reset = 1'b1;
    #1;
    chk("t7_rst_valid",  bus0.valid_out, 0);
    chk("t7_rst_thanks", bus0.thanks_out, 0);
    tick();
    reset     = 1'b0;
    route_req = 5'b11000;
    valid     = 5'b00000;
    #1;
    chk("t7_credit", bus0.credit_count_out, 4);
    chk("t7_valid",  bus0.valid_out, 0);
    chk("t7_thanks", bus0.thanks_out, 0);
    chk("t7_ec",     bus0.ec_wants_to_send_but_cannot, 0);
    tick();
    valid = 5'b11000;
    tail  = 5'b11000;
    #1;
    chk("t7_rr_zero", bus0.thanks_out, 5'b01000);
    tick();
    clear_in();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dynamic_output_arb_para.md
Name: dynamic_output_arb_para

Overview:
Parametrised output port for the dynamic network. It merges NUM_IN input channels onto one output link using wormhole routing: a channel is granted on its route request and holds the link until its tail flit leaves. It adds round-robin fairness, a configurable credit (yummy) counter with overflow detection, and optional header stripping. It sits between the per-input route-decode stage and the outgoing link, replacing the fixed two-input output port.

Parameters:
NUM_IN, 5, number of input channels (2..8).
DATA_WIDTH, 64, flit width in bits.
CREDITS, 4, downstream buffer depth (initial credit count), 1..15.
KILL_HEADERS, 0, when 1 the first flit of every packet is consumed and not forwarded.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
route_req_in  in  NUM_IN  per-channel request for this output; held high for the whole packet.
tail_in  in  NUM_IN  per-channel flag: the current flit is the last flit of its packet.
valid_in  in  NUM_IN  per-channel flit valid.
data_in  in  NUM_IN*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
yummy_in  in  1  credit return from downstream, one credit per cycle.
data_out  out  DATA_WIDTH  flit to the link.
valid_out  out  1  flit on data_out is sent this cycle.
thanks_out  out  NUM_IN  one-hot pulse: the selected channel's flit was consumed.
popped_header_out  out  1  pulse: a header flit was stripped (KILL_HEADERS=1 only).
credit_count_out  out  $clog2(CREDITS+1)  current credit count.
credit_err_out  out  1  sticky flag: a yummy arrived while the count was already CREDITS.
ec_wants_to_send_but_cannot  out  1  the owner has a valid flit but there are 0 credits.

Behaviour:
- Reset values: state IDLE, owner 0, rr_ptr 0, first_flit 1, credit count CREDITS, credit_err 0. All pulse outputs are 0 during and after reset. data_out is don't-care and is driven to 0 when not valid.
- IDLE state: arbitrate over route_req_in, searching from rr_ptr upward and wrapping modulo NUM_IN. On any request, register owner = winner and move to LOCKED on the next cycle. No flit moves in the grant cycle, so there is one cycle of arbitration latency.
- LOCKED state: data_out = data_in[owner] combinationally. Define go = valid_in[owner] & (strip | credits>0), where strip = KILL_HEADERS & first_flit.
  - On go with strip=1: thanks_out[owner]=1, popped_header_out=1, valid_out=0, no credit used.
  - On go with strip=0: valid_out=1, thanks_out[owner]=1, credit decremented.
  - first_flit clears after the first go and is set again on grant.
- Tail: a go with tail_in[owner]=1 returns the block to IDLE next cycle, sets rr_ptr = (owner+1) mod NUM_IN, and sets first_flit=1. A packet consisting of a single tail flit, stripped by KILL_HEADERS, also releases the link.
- route_req_in of the owner is ignored while LOCKED; release happens only on the tail.
- Credits:
  - A send and a yummy in the same cycle leave the count unchanged.
  - A yummy alone increments the count; if the count is already CREDITS, it saturates and credit_err_out is set (cleared only by reset).
  - The count never underflows, because no send is possible at 0.
- ec_wants_to_send_but_cannot = LOCKED & valid_in[owner] & ~strip & credits==0.
- Reset mid-packet abandons the packet: IDLE, full credits, rr_ptr 0. Upstream must also be reset.
- thanks_out is always one-hot or zero, and never asserted in IDLE.

Test Plan:
- After reset, channel 2 sends a 3-flit packet (tail on flit 3) with CREDITS=4 and no yummy -> grant appears one cycle after the request, 3 consecutive valid_out cycles, thanks_out=5'b00100 three times, credit_count_out goes 4→1, then IDLE.
- Channels 0 and 3 request continuously with single-flit packets -> grants alternate 0,3,0,3; no channel wins twice in a row while the other requests.
- Credits start at 4, 6 flits are pending, yummy_in is held low -> 4 flits sent, then ec_wants_to_send_but_cannot=1 and valid_out=0. One yummy pulse -> exactly one more flit is sent.
- A yummy coincides with a send at count 2 -> count stays 2. A yummy at count 4 -> count stays 4 and credit_err_out latches 1 until reset.
- KILL_HEADERS=1, channel 1 sends a 2-flit packet -> cycle 1: popped_header_out=1, valid_out=0, thanks_out[1]=1, credits unchanged. Cycle 2: payload sent with valid_out=1. Then IDLE.
- Reset asserted while LOCKED mid-packet with credits=1 -> next cycle: IDLE, credit_count_out=4, all pulse outputs 0, rr_ptr 0.
